// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-stage registered immediate generator sitting between
// fetch and execute. The opcode is decoded and the sign-extended immediate is
// produced combinationally, then held in an output register. A skid register
// behind it keeps full throughput when the consumer applies backpressure.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  // Format codes reported on fmt
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // The W-suffixed opcodes only exist on a 64-bit datapath
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      w_opcode;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_accept;
  logic            w_outFree;

  logic            r_outValid;
  logic [XLEN-1:0] r_outImm;
  logic [2:0]      r_outFmt;
  logic            r_outIllegal;
  logic            r_skidValid;
  logic [XLEN-1:0] r_skidImm;
  logic [2:0]      r_skidFmt;
  logic            r_skidIllegal;

  assign w_opcode = instruction[6:0];

  // Decode the opcode and build the immediate at 64 bits; narrower datapaths
  // simply keep the low XLEN bits, which are already correctly sign-extended.
  always_comb begin
    w_imm64   = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
        w_fmt   = FMT_I;
      end
      7'b1110011: begin
        if (ZIMM_EN && instruction[14]) begin
          w_imm64 = {59'b0, instruction[19:15]};
          w_fmt   = FMT_Z;
        end else begin
          w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
          w_fmt   = FMT_I;
        end
      end
      7'b0011011: begin
        if (RV64) begin
          w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
          w_fmt   = FMT_I;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b0100011: begin
        w_imm64 = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
        w_fmt   = FMT_S;
      end
      7'b1100011: begin
        w_imm64 = {{51{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
        w_fmt   = FMT_B;
      end
      7'b1101111: begin
        w_imm64 = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
        w_fmt   = FMT_J;
      end
      7'b0110111, 7'b0010111: begin
        w_imm64 = {{32{instruction[31]}}, instruction[31:12], 12'b0};
        w_fmt   = FMT_U;
      end
      7'b0110011: begin
        w_fmt = FMT_R;
      end
      7'b0111011: begin
        if (RV64) begin
          w_fmt = FMT_R;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm = w_imm64[XLEN-1:0];

  // The stage accepts whenever the skid slot is empty; the output register
  // is free to load when it is empty or being consumed this cycle.
  assign w_accept  = in_valid && !r_skidValid;
  assign w_outFree = !r_outValid || out_ready;

  // Output and skid registers: skid always drains first to preserve order,
  // a held output diverts the accepted word into skid, flush/reset wipe both.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_outValid    <= 1'b0;
      r_outImm      <= '0;
      r_outFmt      <= FMT_NONE;
      r_outIllegal  <= 1'b0;
      r_skidValid   <= 1'b0;
      r_skidImm     <= '0;
      r_skidFmt     <= FMT_NONE;
      r_skidIllegal <= 1'b0;
    end else if (w_outFree) begin
      if (r_skidValid) begin
        r_outValid   <= 1'b1;
        r_outImm     <= r_skidImm;
        r_outFmt     <= r_skidFmt;
        r_outIllegal <= r_skidIllegal;
        r_skidValid  <= 1'b0;
      end else if (w_accept) begin
        r_outValid   <= 1'b1;
        r_outImm     <= w_imm;
        r_outFmt     <= w_fmt;
        r_outIllegal <= w_illegal;
      end else begin
        r_outValid   <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidValid   <= 1'b1;
      r_skidImm     <= w_imm;
      r_skidFmt     <= w_fmt;
      r_skidIllegal <= w_illegal;
    end
  end

  assign in_ready  = !r_skidValid;
  assign out_valid = r_outValid;
  assign imm       = r_outImm;
  assign fmt       = r_outFmt;
  assign illegal   = r_outIllegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe. Three instances share the
// same stimulus: 32-bit with zimm, 64-bit with zimm, and 32-bit without zimm.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic [31:0] instruction;
  logic        outReady;

  logic        inReadyA, outValidA, illegalA;
  logic [31:0] immA;
  logic [2:0]  fmtA;

  logic        inReadyB, outValidB, illegalB;
  logic [63:0] immB;
  logic [2:0]  fmtB;

  logic        inReadyC, outValidC, illegalC;
  logic [31:0] immC;
  logic [2:0]  fmtC;

  int checkCount = 0;
  int passCount  = 0;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b1)) dutA (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyA),
    .instruction(instruction), .out_valid(outValidA), .out_ready(outReady),
    .imm(immA), .fmt(fmtA), .illegal(illegalA)
  );

  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1'b1)) dutB (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyB),
    .instruction(instruction), .out_valid(outValidB), .out_ready(outReady),
    .imm(immB), .fmt(fmtB), .illegal(illegalB)
  );

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b0)) dutC (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyC),
    .instruction(instruction), .out_valid(outValidC), .out_ready(outReady),
    .imm(immC), .fmt(fmtC), .illegal(illegalC)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 unit after the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic ordy, input logic fl, input logic rs);
    inValid     = v;
    instruction = ins;
    outReady    = ordy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Checks all visible fields of the 32-bit zimm instance
  task automatic checkA(input string tag, input logic v, input logic [31:0] i,
                        input logic [2:0] f, input logic il);
    checkOutput({tag, ".valid"},   {63'b0, outValidA}, {63'b0, v});
    checkOutput({tag, ".imm"},     {32'b0, immA},      {32'b0, i});
    checkOutput({tag, ".fmt"},     {61'b0, fmtA},      {61'b0, f});
    checkOutput({tag, ".illegal"}, {63'b0, illegalA},  {63'b0, il});
  endtask

  initial begin
    inValid = 0; instruction = '0; outReady = 1; flush = 0; rst = 1;

    // Reset state
    applyStimulus(0, 32'h0, 1, 0, 1);
    applyStimulus(0, 32'h0, 1, 0, 1);
    checkA("reset", 0, 32'h0, 3'd7, 0);
    checkOutput("reset.inReady", {63'b0, inReadyA}, 64'd1);

    // addi x1,x0,-1
    applyStimulus(1, 32'hFFF00093, 1, 0, 0);
    checkA("addi", 1, 32'hFFFFFFFF, 3'd1, 0);
    checkOutput("addi.imm64", immB, 64'hFFFFFFFFFFFFFFFF);

    // beq -4
    applyStimulus(1, 32'hFE000EE3, 1, 0, 0);
    checkA("beq", 1, 32'hFFFFFFFC, 3'd3, 0);

    // lui with bit 31 set
    applyStimulus(1, 32'h800002B7, 1, 0, 0);
    checkA("lui", 1, 32'h80000000, 3'd4, 0);
    checkOutput("lui.imm64", immB, 64'hFFFFFFFF80000000);
    checkOutput("lui.fmt64", {61'b0, fmtB}, 64'd4);

    // sw x1,-4(x2)
    applyStimulus(1, 32'hFE112E23, 1, 0, 0);
    checkA("sw", 1, 32'hFFFFFFFC, 3'd2, 0);

    // jal x0,-4
    applyStimulus(1, 32'hFFDFF06F, 1, 0, 0);
    checkA("jal", 1, 32'hFFFFFFFC, 3'd5, 0);

    // csrrwi: zimm with ZIMM_EN, plain I-type without
    applyStimulus(1, 32'h300FD073, 1, 0, 0);
    checkA("csrrwi", 1, 32'h0000001F, 3'd6, 0);
    checkOutput("csrrwi.immNoZ", {32'b0, immC}, 64'h300);
    checkOutput("csrrwi.fmtNoZ", {61'b0, fmtC}, 64'd1);

    // Unknown opcode
    applyStimulus(1, 32'h0000007F, 1, 0, 0);
    checkA("bad", 1, 32'h0, 3'd7, 1);

    // R-type add
    applyStimulus(1, 32'h00000033, 1, 0, 0);
    checkA("add", 1, 32'h0, 3'd0, 0);

    // addw: illegal on 32-bit, R-type on 64-bit
    applyStimulus(1, 32'h0000003B, 1, 0, 0);
    checkA("addw32", 1, 32'h0, 3'd7, 1);
    checkOutput("addw64.fmt", {61'b0, fmtB}, 64'd0);
    checkOutput("addw64.illegal", {63'b0, illegalB}, 64'd0);

    // Drain to empty
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("idle.valid", {63'b0, outValidA}, 64'd0);

    // Backpressure: A,B accepted while output held, C waits
    applyStimulus(1, 32'h00100093, 0, 0, 0);
    checkOutput("bpA.imm", {32'b0, immA}, 64'd1);
    checkOutput("bpA.inReady", {63'b0, inReadyA}, 64'd1);
    applyStimulus(1, 32'h00200093, 0, 0, 0);
    checkOutput("bpB.imm", {32'b0, immA}, 64'd1);
    checkOutput("bpB.inReady", {63'b0, inReadyA}, 64'd0);
    applyStimulus(1, 32'h00300093, 0, 0, 0);
    checkOutput("bpHold.imm", {32'b0, immA}, 64'd1);
    checkOutput("bpHold.valid", {63'b0, outValidA}, 64'd1);
    checkOutput("bpHold.inReady", {63'b0, inReadyA}, 64'd0);
    applyStimulus(1, 32'h00300093, 1, 0, 0);
    checkOutput("relB.imm", {32'b0, immA}, 64'd2);
    checkOutput("relB.inReady", {63'b0, inReadyA}, 64'd1);
    applyStimulus(1, 32'h00300093, 1, 0, 0);
    checkOutput("relC.imm", {32'b0, immA}, 64'd3);
    checkOutput("relC.valid", {63'b0, outValidA}, 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("relEnd.valid", {63'b0, outValidA}, 64'd0);

    // Flush with both entries full, plus a word offered during flush
    applyStimulus(1, 32'h00500093, 0, 0, 0);
    applyStimulus(1, 32'h00600093, 0, 0, 0);
    checkOutput("preFlush.inReady", {63'b0, inReadyA}, 64'd0);
    applyStimulus(1, 32'h00700093, 1, 1, 0);
    checkA("flush", 0, 32'h0, 3'd7, 0);
    checkOutput("flush.inReady", {63'b0, inReadyA}, 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("postFlush.valid", {63'b0, outValidA}, 64'd0);
    applyStimulus(1, 32'h00800093, 1, 0, 0);
    checkA("postFlush.new", 1, 32'h8, 3'd1, 0);

    // Reset in the middle of a stall
    applyStimulus(1, 32'h00900093, 0, 0, 0);
    applyStimulus(1, 32'h00A00093, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 1);
    checkA("rstStall", 0, 32'h0, 3'd7, 0);
    checkOutput("rstStall.inReady", {63'b0, inReadyA}, 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkOutput("postRst.valid", {63'b0, outValidA}, 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
